// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: two-port (CPU/DMA) front end for the hyperram controller.
// Build option: define HYPERRAM_ARB_FIXED_PRIORITY_EN to make port 0 always win ties.
module hyperram_arbiter #(
    parameter int unsigned WAIT_LATENCY = 6,
    parameter int unsigned DONE_LATENCY = 40,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter bit          TIMED_READ   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wmask,
    output logic        req0_ack,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wmask,
    output logic        req1_ack,
    output logic [31:0] req1_rdata,
    output logic        hr_transaction_begin,
    output logic        hr_write_enable,
    output logic [31:0] hr_address,
    output logic [31:0] hr_write_data,
    output logic [3:0]  hr_write_mask,
    output logic [5:0]  hr_wait_latency,
    output logic [5:0]  hr_done_latency,
    output logic        hr_timed_read,
    input  logic [31:0] hr_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

    // BUSY runs from this value down to 0, i.e. DONE_LATENCY + GUARD_CYCLES cycles
    localparam logic [7:0] LOAD = 8'(DONE_LATENCY + GUARD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick1;

`ifdef HYPERRAM_ARB_FIXED_PRIORITY_EN
    assign pick1 = req1_valid & ~req0_valid;
`else
    assign pick1 = req1_valid & (~req0_valid | ~last_q);
`endif

    // State and command registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state: grant in IDLE, time the controller, capture read data
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d   = pick1;
                    last_d  = pick1;
                    we_d    = pick1 ? req1_write   : req0_write;
                    addr_d  = pick1 ? req1_address : req0_address;
                    wdata_d = pick1 ? req1_wdata   : req0_wdata;
                    wmask_d = pick1 ? req1_wmask   : req0_wmask;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LOAD;
                state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    // Capture on entry to DONE so rdata is valid alongside the ack
                    if (!we_q) begin
                        if (gnt_q) rdata1_d = hr_read_data;
                        else       rdata0_d = hr_read_data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hr_transaction_begin = (state_q == ISSUE);
    assign req0_ack             = (state_q == DONE) & ~gnt_q;
    assign req1_ack             = (state_q == DONE) &  gnt_q;
    assign busy                 = (state_q != IDLE);
    assign req0_rdata           = rdata0_q;
    assign req1_rdata           = rdata1_q;
    assign hr_write_enable      = we_q;
    assign hr_address           = addr_q;
    assign hr_write_data        = wdata_q;
    assign hr_write_mask        = wmask_q;
    assign hr_wait_latency      = 6'(WAIT_LATENCY);
    assign hr_done_latency      = 6'(DONE_LATENCY);
    assign hr_timed_read        = TIMED_READ;

endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: directed checks of the two-port hyperram arbiter.
// Runs with DONE_LATENCY=4, GUARD_CYCLES=2, so ack lands 8 cycles after valid.
module tb_hyperram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_write;
    logic [31:0] req0_address, req0_wdata;
    logic [3:0]  req0_wmask;
    logic        req0_ack;
    logic [31:0] req0_rdata;
    logic        req1_valid, req1_write;
    logic [31:0] req1_address, req1_wdata;
    logic [3:0]  req1_wmask;
    logic        req1_ack;
    logic [31:0] req1_rdata;
    logic        hr_transaction_begin, hr_write_enable, hr_timed_read;
    logic [31:0] hr_address, hr_write_data, hr_read_data;
    logic [3:0]  hr_write_mask;
    logic [5:0]  hr_wait_latency, hr_done_latency;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hyperram_arbiter #(
        .WAIT_LATENCY(6),
        .DONE_LATENCY(4),
        .GUARD_CYCLES(2),
        .TIMED_READ(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_write(req0_write),
        .req0_address(req0_address),
        .req0_wdata(req0_wdata),
        .req0_wmask(req0_wmask),
        .req0_ack(req0_ack),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid),
        .req1_write(req1_write),
        .req1_address(req1_address),
        .req1_wdata(req1_wdata),
        .req1_wmask(req1_wmask),
        .req1_ack(req1_ack),
        .req1_rdata(req1_rdata),
        .hr_transaction_begin(hr_transaction_begin),
        .hr_write_enable(hr_write_enable),
        .hr_address(hr_address),
        .hr_write_data(hr_write_data),
        .hr_write_mask(hr_write_mask),
        .hr_wait_latency(hr_wait_latency),
        .hr_done_latency(hr_done_latency),
        .hr_timed_read(hr_timed_read),
        .hr_read_data(hr_read_data),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || req0_ack !== 1'b0 || req1_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b ack0=%b ack1=%b exp 0/0/0",
                     busy, req0_ack, req1_ack);
        end
        checks++;
        if (hr_transaction_begin !== 1'b0 || hr_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_hr_ctrl begin=%b we=%b exp 0/0",
                     hr_transaction_begin, hr_write_enable);
        end
        checks++;
        if (hr_address !== 32'd0 || hr_write_data !== 32'd0 ||
            hr_write_mask !== 4'd0) begin
            failures++;
            $display("FAIL reset_hr_cmd addr=%h wdata=%h mask=%b exp 0",
                     hr_address, hr_write_data, hr_write_mask);
        end
        checks++;
        if (req0_rdata !== 32'd0 || req1_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata r0=%h r1=%h exp 0", req0_rdata, req1_rdata);
        end
        checks++;
        if (hr_wait_latency !== 6'd6 || hr_done_latency !== 6'd4 ||
            hr_timed_read !== 1'b0) begin
            failures++;
            $display("FAIL reset_consts wait=%0d done=%0d timed=%b exp 6/4/0",
                     hr_wait_latency, hr_done_latency, hr_timed_read);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int beg_at;
        int nbeg;
        int ack_at;
        beg_at = -1;
        nbeg = 0;
        ack_at = -1;
        hr_read_data = 32'hCCCC_DDDD;
        req0_write = 1'b0;
        req0_address = 32'h1234_5678;
        req0_valid = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (hr_transaction_begin) begin
                nbeg++;
                beg_at = n;
                checks++;
                if (hr_address !== 32'h1234_5678 || hr_write_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL read_cmd addr=%h we=%b exp 12345678/0",
                             hr_address, hr_write_enable);
                end
            end
            if (req0_ack || req1_ack) begin
                ack_at = n;
                checks++;
                if (req1_ack !== 1'b0 || req0_rdata !== 32'hCCCC_DDDD) begin
                    failures++;
                    $display("FAIL read_ack_data ack1=%b rdata=%h exp 0/ccccdddd",
                             req1_ack, req0_rdata);
                end
                break;
            end
        end
        req0_valid = 1'b0;
        checks++;
        if (beg_at !== 1 || nbeg !== 1) begin
            failures++;
            $display("FAIL read_begin at=%0d count=%0d exp 1/1", beg_at, nbeg);
        end
        checks++;
        if (ack_at !== 8) begin
            failures++;
            $display("FAIL read_ack_cycle got=%0d exp 8", ack_at);
        end
        tick();
        checks++;
        if (req0_rdata !== 32'hCCCC_DDDD || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_after rdata=%h busy=%b exp ccccdddd/0",
                     req0_rdata, busy);
        end
    endtask

    task automatic test_write();
        int ack_at;
        int bad_hold;
        int nbeg;
        ack_at = -1;
        bad_hold = 0;
        nbeg = 0;
        hr_read_data = 32'hDEAD_BEEF;
        req1_write = 1'b1;
        req1_address = 32'h0000_0040;
        req1_wdata = 32'hA5A5_A5A5;
        req1_wmask = 4'b0011;
        req1_valid = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 2) begin
                req1_wdata = 32'h0;
                req1_wmask = 4'b1111;
            end
            if (hr_transaction_begin) nbeg++;
            if (hr_write_enable !== 1'b1 || hr_write_data !== 32'hA5A5_A5A5 ||
                hr_write_mask !== 4'b0011 || hr_address !== 32'h0000_0040)
                bad_hold++;
            if (req0_ack) bad_hold++;
            if (req1_ack) begin
                ack_at = n;
                break;
            end
        end
        req1_valid = 1'b0;
        checks++;
        if (bad_hold !== 0) begin
            failures++;
            $display("FAIL write_hold bad_cycles=%0d exp 0", bad_hold);
        end
        checks++;
        if (ack_at !== 8 || nbeg !== 1) begin
            failures++;
            $display("FAIL write_ack ack_at=%0d begins=%0d exp 8/1", ack_at, nbeg);
        end
        tick();
        checks++;
        if (req1_rdata !== 32'd0 || req0_rdata !== 32'hCCCC_DDDD) begin
            failures++;
            $display("FAIL write_rdata r1=%h r0=%h exp 0/ccccdddd",
                     req1_rdata, req0_rdata);
        end
    endtask

    task automatic test_contention();
        logic [3:0] order;
        logic [3:0] exp_order;
        int k;
        int nbeg;
        int both;
`ifdef HYPERRAM_ARB_FIXED_PRIORITY_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        order = 4'b0;
        k = 0;
        nbeg = 0;
        both = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_write = 1'b0;
        req0_address = 32'h0000_0100;
        req1_write = 1'b0;
        req1_address = 32'h0000_0200;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (hr_transaction_begin) nbeg++;
            if (req0_ack && req1_ack) both++;
            if (req0_ack || req1_ack) begin
                order[k] = req1_ack;
                k++;
                if (k == 4) break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (k !== 4 || order !== exp_order) begin
            failures++;
            $display("FAIL contention_order acks=%0d order(lsb first)=%b exp 4/%b",
                     k, order, exp_order);
        end
        checks++;
        if (both !== 0 || nbeg !== 4) begin
            failures++;
            $display("FAIL contention_acks simultaneous=%0d begins=%0d exp 0/4",
                     both, nbeg);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL contention_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        int bad;
        int ack_at;
        bad = 0;
        ack_at = -1;
        hr_read_data = 32'h5555_6666;
        req0_write = 1'b0;
        req0_address = 32'h0000_0800;
        req0_valid = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        rst = 1'b1;
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || req0_ack !== 1'b0 || hr_address !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_abort busy=%b ack0=%b addr=%h exp 0/0/0",
                     busy, req0_ack, hr_address);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (busy || req0_ack || req1_ack || hr_transaction_begin) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rstmid_quiet bad_cycles=%0d exp 0", bad);
        end
        hr_read_data = 32'h1111_2222;
        req0_address = 32'h0000_1000;
        req0_valid = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (req0_ack) begin
                ack_at = n;
                break;
            end
        end
        req0_valid = 1'b0;
        checks++;
        if (ack_at !== 8 || req0_rdata !== 32'h1111_2222) begin
            failures++;
            $display("FAIL rstmid_recover ack_at=%0d rdata=%h exp 8/11112222",
                     ack_at, req0_rdata);
        end
        tick();
    endtask

    task automatic test_drop_valid();
        int ack_at;
        int bad;
        ack_at = -1;
        bad = 0;
        hr_read_data = 32'h3333_4444;
        req0_write = 1'b0;
        req0_address = 32'h0000_2000;
        req0_valid = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 3) begin
                req0_valid = 1'b0;
                req0_address = 32'hFFFF_0000;
            end
            if (hr_address !== 32'h0000_2000) bad++;
            if (req0_ack) begin
                ack_at = n;
                break;
            end
        end
        checks++;
        if (ack_at !== 8 || req0_rdata !== 32'h3333_4444) begin
            failures++;
            $display("FAIL drop_ack ack_at=%0d rdata=%h exp 8/33334444",
                     ack_at, req0_rdata);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL drop_addr_hold bad_cycles=%0d exp 0", bad);
        end
        bad = 0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (busy || hr_transaction_begin || req0_ack || req1_ack) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL drop_idle bad_cycles=%0d exp 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req0_write = 1'b0;
        req0_address = 32'd0;
        req0_wdata = 32'd0;
        req0_wmask = 4'd0;
        req1_valid = 1'b0;
        req1_write = 1'b0;
        req1_address = 32'd0;
        req1_wdata = 32'd0;
        req1_wmask = 4'd0;
        hr_read_data = 32'd0;
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_reset_mid_busy();
        test_drop_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
- Shares the single hyperram controller between two requesters, port 0 (CPU) and port 1 (DMA).
- Sequences each transaction: latches the command, pulses transaction_begin, then counts the controller's fixed completion time.
- Returns read data and a one-cycle ack to the winning port.
- Sits directly in front of the hyperram controller; only this block drives the controller's command inputs.

Parameters:
- WAIT_LATENCY, 6, value driven on hr_wait_latency (6 bits).
- DONE_LATENCY, 40, value driven on hr_done_latency (6 bits), range 1..63.
- GUARD_CYCLES, 2, extra idle cycles after DONE_LATENCY before completion, range 0..15.
- TIMED_READ, 0, constant driven on hr_timed_read.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request pending; held until req0_ack
- req0_write  in  1  1 = write, 0 = read
- req0_address  in  32  byte address
- req0_wdata  in  32  write data
- req0_wmask  in  4  byte write mask
- req0_ack  out  1  one-cycle completion pulse
- req0_rdata  out  32  read data, valid with req0_ack on reads
- req1_*  same set as port 0, for port 1
- hr_transaction_begin  out  1  one-cycle start pulse to the controller
- hr_write_enable  out  1  to controller
- hr_address  out  32  to controller
- hr_write_data  out  32  to controller
- hr_write_mask  out  4  to controller
- hr_wait_latency  out  6  to controller
- hr_done_latency  out  6  to controller
- hr_timed_read  out  1  to controller
- hr_read_data  in  32  controller read result, stable once done
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, counter = 0, last_grant = 1, so port 0 wins the first tie.
  - All acks, hr_transaction_begin, hr_write_enable and busy = 0.
  - hr_address, hr_write_data, hr_write_mask and reqN_rdata = 0.
  - hr_wait_latency, hr_done_latency and hr_timed_read are constant from parameters.
- States: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If no valid request, stay.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port that is not last_grant (round-robin).
  - On grant: register write/address/wdata/wmask onto the hr_* outputs, record grant in last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - hr_transaction_begin = 1.
  - Load counter with DONE_LATENCY + GUARD_CYCLES − 1 (8-bit counter).
  - Go to BUSY.
- BUSY:
  - Decrement the counter each cycle; go to DONE when the counter is 0.
  - BUSY lasts exactly L = DONE_LATENCY + GUARD_CYCLES cycles.
  - The hr_* command outputs hold stable throughout.
- DONE (1 cycle):
  - Ack of the granted port = 1.
  - On a read, that port's rdata <= hr_read_data.
  - On a write, rdata is unchanged.
  - Go to IDLE.
- Latency: valid seen in IDLE at cycle T -> begin at T+1 -> ack at T+2+L.
- Arbitration is not re-evaluated until IDLE. A requester keeping valid high after its ack is treated as a new request and gets one IDLE turnaround cycle.
- Requester dropping valid mid-transaction: ignored; the transaction completes and the ack is still pulsed.
- Request fields are sampled only in IDLE; later changes have no effect.
- Reset mid-transaction: the FSM aborts to IDLE with no ack and no further begin pulse.
- The two acks are never high in the same cycle.

Optional Feature:
- Macro: HYPERRAM_ARB_FIXED_PRIORITY_EN.
- Defined: port 0 always wins when both ports are valid; last_grant is not used.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read, DONE_LATENCY = 4, GUARD_CYCLES = 2:
  - Stimulus: req0 read of 0x12345678 at T; controller presents hr_read_data = 0xCCCCDDDD.
  - Required: hr_transaction_begin high only at T+1 with hr_address = 0x12345678 and hr_write_enable = 0; req0_ack at T+8; req0_rdata = 0xCCCCDDDD.
- Write:
  - Stimulus: req1 write, wdata 0xA5A5A5A5, wmask 4'b0011.
  - Required: hr_write_enable = 1, hr_write_data = 0xA5A5A5A5, hr_write_mask = 0011 held from T+1 through ack; req1_rdata unchanged.
- Contention after reset:
  - Stimulus: both ports valid continuously for four transactions.
  - Required: grant order 0, 1, 0, 1; exactly one ack per transaction; no simultaneous acks.
- Fixed priority (HYPERRAM_ARB_FIXED_PRIORITY_EN defined):
  - Stimulus: same as the contention test.
  - Required: port 0 wins all four transactions while it stays valid.
- Reset mid-BUSY:
  - Stimulus: assert rst for 1 cycle, 3 cycles into BUSY.
  - Required: busy = 0 next cycle, no ack; a new req0 afterwards completes normally.
- Drop valid:
  - Stimulus: req0 deasserts valid during BUSY.
  - Required: req0_ack still pulses at T+2+L; the next IDLE with no requests stays idle.
